// File: rtl/pipe_ctrl.sv
// Pipeline control unit: thermometer stall vector, registered multi-cycle flush
// with redirect PC, stall watchdog and wrapping performance counters.
module pipe_ctrl #(
    parameter int NSTAGE     = 6,
    parameter int PC_W       = 32,
    parameter int FLUSH_LEN  = 1,
    parameter int WDOG_LIMIT = 255,
    parameter int CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NSTAGE-1:0] stallreq,
    input  logic              flushreq,
    input  logic [PC_W-1:0]   flush_pc_i,
    input  logic              clr_cnt,
    output logic [NSTAGE-1:0] stall,
    output logic              flush,
    output logic [PC_W-1:0]   new_pc,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_events,
    output logic              wdog_timeout
);

    localparam int FC_W = $clog2(FLUSH_LEN + 1);
    localparam int WD_W = $clog2(WDOG_LIMIT + 1);
    localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_LEN);
    localparam logic [WD_W-1:0] WD_MAX  = WD_W'(WDOG_LIMIT);

    logic [FC_W-1:0]   flush_cnt;
    logic [WD_W-1:0]   wdog_cnt;
    logic [NSTAGE-1:0] therm;

    // A stage stalls whenever it or any later stage requests a stall.
    always_comb begin
        therm = '0;
        for (int k = 0; k < NSTAGE; k++) begin
            therm[k] = |(stallreq >> k);
        end
    end

    assign flush = (flush_cnt != '0);
    assign stall = (rst || flush) ? '0 : therm;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_cnt <= '0;
            new_pc    <= '0;
        end else if (flushreq) begin
            flush_cnt <= FC_LOAD;
            new_pc    <= flush_pc_i;
        end else if (flush) begin
            flush_cnt <= flush_cnt - FC_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else if (clr_cnt) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (stall[0]) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            if (flushreq) begin
                flush_events <= flush_events + CNT_W'(1);
            end
        end
    end

    // Counter saturates at the limit; the flag is raised on the edge that reaches it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_cnt     <= '0;
            wdog_timeout <= 1'b0;
        end else if (clr_cnt) begin
            wdog_cnt     <= '0;
            wdog_timeout <= 1'b0;
        end else if (stall != '0) begin
            if (wdog_cnt != WD_MAX) begin
                wdog_cnt <= wdog_cnt + WD_W'(1);
            end
            if (wdog_cnt == WD_MAX - WD_W'(1)) begin
                wdog_timeout <= 1'b1;
            end
        end else begin
            wdog_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl: vector table, hand-written corner sequences and a
// randomized run checked against a cycle-level reference model.
module tb_pipe_ctrl;

    localparam int NSTAGE     = 6;
    localparam int PC_W       = 32;
    localparam int FLUSH_LEN  = 2;
    localparam int WDOG_LIMIT = 4;
    localparam int CNT_W      = 4;
    localparam int CNT_MOD    = 1 << CNT_W;

    logic              clk;
    logic              rst;
    logic [NSTAGE-1:0] stallreq;
    logic              flushreq;
    logic [PC_W-1:0]   flush_pc_i;
    logic              clr_cnt;
    logic [NSTAGE-1:0] stall;
    logic              flush;
    logic [PC_W-1:0]   new_pc;
    logic [CNT_W-1:0]  stall_cycles;
    logic [CNT_W-1:0]  flush_events;
    logic              wdog_timeout;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state, updated once per clock edge.
    int          m_remain;
    logic [31:0] m_pc;
    int          m_sc;
    int          m_fe;
    int          m_run;
    logic        m_to;

    typedef struct {
        logic [NSTAGE-1:0] sr;
        logic              fr;
        logic [31:0]       pc;
        logic              clr;
        logic [NSTAGE-1:0] exp_stall;
        logic              exp_flush;
    } vec_t;

    vec_t tbl[10];

    pipe_ctrl #(
        .NSTAGE(NSTAGE), .PC_W(PC_W), .FLUSH_LEN(FLUSH_LEN),
        .WDOG_LIMIT(WDOG_LIMIT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .stallreq(stallreq), .flushreq(flushreq),
        .flush_pc_i(flush_pc_i), .clr_cnt(clr_cnt), .stall(stall), .flush(flush),
        .new_pc(new_pc), .stall_cycles(stall_cycles), .flush_events(flush_events),
        .wdog_timeout(wdog_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [NSTAGE-1:0] thermo(input logic [NSTAGE-1:0] r);
        int h = -1;
        for (int i = 0; i < NSTAGE; i++) begin
            if (r[i]) h = i;
        end
        if (h < 0) return '0;
        return NSTAGE'((1 << (h + 1)) - 1);
    endfunction

    function automatic logic [NSTAGE-1:0] modelStall();
        if (rst || m_remain > 0) return '0;
        return thermo(stallreq);
    endfunction

    task automatic modelReset();
        m_remain = 0;
        m_pc     = 0;
        m_sc     = 0;
        m_fe     = 0;
        m_run    = 0;
        m_to     = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [NSTAGE-1:0] sr, input logic fr,
                                 input logic [31:0] pc, input logic clr);
        @(negedge clk);
        stallreq   = sr;
        flushreq   = fr;
        flush_pc_i = pc;
        clr_cnt    = clr;
        #1;
    endtask

    task automatic checkModel();
        checkOutput("stall",        32'(stall),        32'(modelStall()));
        checkOutput("flush",        32'(flush),        32'(m_remain > 0));
        checkOutput("new_pc",       new_pc,            m_pc);
        checkOutput("stall_cycles", 32'(stall_cycles), 32'(m_sc));
        checkOutput("flush_events", 32'(flush_events), 32'(m_fe));
        checkOutput("wdog_timeout", 32'(wdog_timeout), 32'(m_to));
    endtask

    // Advance the model by the rules for one clock edge, then let the DUT take it.
    task automatic clockEdge();
        logic [NSTAGE-1:0] e;
        e = modelStall();
        if (clr_cnt) begin
            m_sc  = 0;
            m_fe  = 0;
            m_run = 0;
            m_to  = 1'b0;
        end else begin
            if (e[0]) m_sc = (m_sc + 1) % CNT_MOD;
            if (flushreq) m_fe = (m_fe + 1) % CNT_MOD;
            if (e != '0) m_run++;
            else m_run = 0;
            if (m_run >= WDOG_LIMIT) m_to = 1'b1;
        end
        if (flushreq) begin
            m_remain = FLUSH_LEN;
            m_pc     = flush_pc_i;
        end else if (m_remain > 0) begin
            m_remain--;
        end
        @(posedge clk);
    endtask

    task automatic cycle(input logic [NSTAGE-1:0] sr, input logic fr,
                         input logic [31:0] pc, input logic clr);
        applyStimulus(sr, fr, pc, clr);
        checkModel();
        clockEdge();
    endtask

    initial begin
        tbl[0] = '{6'b000001, 1'b0, 32'h0,   1'b0, 6'b000001, 1'b0};
        tbl[1] = '{6'b000100, 1'b0, 32'h0,   1'b0, 6'b000111, 1'b0};
        tbl[2] = '{6'b001000, 1'b0, 32'h0,   1'b0, 6'b001111, 1'b0};
        tbl[3] = '{6'b101010, 1'b0, 32'h0,   1'b0, 6'b111111, 1'b0};
        tbl[4] = '{6'b000000, 1'b0, 32'h0,   1'b0, 6'b000000, 1'b0};
        tbl[5] = '{6'b001000, 1'b0, 32'h0,   1'b0, 6'b001111, 1'b0};
        tbl[6] = '{6'b001000, 1'b1, 32'h100, 1'b0, 6'b001111, 1'b0};
        tbl[7] = '{6'b001000, 1'b0, 32'h0,   1'b0, 6'b000000, 1'b1};
        tbl[8] = '{6'b001000, 1'b0, 32'h0,   1'b0, 6'b000000, 1'b1};
        tbl[9] = '{6'b001000, 1'b0, 32'h0,   1'b0, 6'b001111, 1'b0};

        rst        = 1'b1;
        stallreq   = '0;
        flushreq   = 1'b0;
        flush_pc_i = '0;
        clr_cnt    = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        stallreq = 6'b010000;
        #1;
        checkOutput("reset_stall",  32'(stall),        32'h0);
        checkOutput("reset_flush",  32'(flush),        32'h0);
        checkOutput("reset_new_pc", new_pc,            32'h0);
        checkOutput("reset_sc",     32'(stall_cycles), 32'h0);
        checkOutput("reset_fe",     32'(flush_events), 32'h0);
        checkOutput("reset_wdog",   32'(wdog_timeout), 32'h0);
        rst      = 1'b0;
        stallreq = '0;

        // Thermometer table and single flush with a held stall request.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(tbl[i].sr, tbl[i].fr, tbl[i].pc, tbl[i].clr);
            checkModel();
            checkOutput($sformatf("tbl%0d_stall", i), 32'(stall), 32'(tbl[i].exp_stall));
            checkOutput($sformatf("tbl%0d_flush", i), 32'(flush), 32'(tbl[i].exp_flush));
            clockEdge();
        end
        applyStimulus('0, 1'b0, 32'h0, 1'b0);
        checkOutput("flush1_new_pc", new_pc, 32'h100);
        checkOutput("flush1_events", 32'(flush_events), 32'h1);
        clockEdge();

        // Back-to-back flush: no gap, later target wins.
        cycle('0, 1'b1, 32'h200, 1'b0);
        applyStimulus('0, 1'b1, 32'h300, 1'b0);
        checkModel();
        checkOutput("b2b_first_flush", 32'(flush), 32'h1);
        clockEdge();
        for (int i = 0; i < FLUSH_LEN; i++) begin
            applyStimulus('0, 1'b0, 32'h0, 1'b0);
            checkModel();
            checkOutput("b2b_flush_held", 32'(flush), 32'h1);
            checkOutput("b2b_new_pc", new_pc, 32'h300);
            clockEdge();
        end
        applyStimulus('0, 1'b0, 32'h0, 1'b0);
        checkModel();
        checkOutput("b2b_flush_end", 32'(flush), 32'h0);
        checkOutput("b2b_events", 32'(flush_events), 32'h3);
        clockEdge();

        // Watchdog: a run one short of the limit, then a run that reaches it.
        cycle('0, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < WDOG_LIMIT - 1; i++) cycle(6'b000100, 1'b0, 32'h0, 1'b0);
        applyStimulus('0, 1'b0, 32'h0, 1'b0);
        checkModel();
        checkOutput("wdog_short_run", 32'(wdog_timeout), 32'h0);
        clockEdge();
        for (int i = 0; i < WDOG_LIMIT; i++) cycle(6'b000100, 1'b0, 32'h0, 1'b0);
        applyStimulus('0, 1'b0, 32'h0, 1'b0);
        checkModel();
        checkOutput("wdog_fired", 32'(wdog_timeout), 32'h1);
        clockEdge();
        cycle('0, 1'b0, 32'h0, 1'b0);
        applyStimulus('0, 1'b0, 32'h0, 1'b1);
        checkOutput("wdog_sticky", 32'(wdog_timeout), 32'h1);
        clockEdge();
        applyStimulus('0, 1'b0, 32'h0, 1'b0);
        checkModel();
        checkOutput("wdog_cleared", 32'(wdog_timeout), 32'h0);
        clockEdge();

        // Counter wrap, then clear beating a simultaneous increment.
        for (int i = 0; i < 17; i++) cycle(6'b000001, 1'b0, 32'h0, 1'b0);
        applyStimulus(6'b000001, 1'b0, 32'h0, 1'b1);
        checkModel();
        checkOutput("sc_wrapped", 32'(stall_cycles), 32'h1);
        clockEdge();
        applyStimulus('0, 1'b0, 32'h0, 1'b0);
        checkModel();
        checkOutput("sc_clr_priority", 32'(stall_cycles), 32'h0);
        clockEdge();

        // Randomized run against the model.
        for (int i = 0; i < 400; i++) begin
            logic [NSTAGE-1:0] sr;
            sr = ($urandom_range(0, 3) == 0) ? '0 : NSTAGE'($urandom);
            cycle(sr, ($urandom_range(0, 7) == 0), $urandom, ($urandom_range(0, 31) == 0));
        end

        // Asynchronous reset between edges while a flush is active.
        cycle(6'b001000, 1'b1, 32'hABCD_0000, 1'b0);
        applyStimulus(6'b001000, 1'b0, 32'h0, 1'b0);
        checkModel();
        checkOutput("mid_flush_active", 32'(flush), 32'h1);
        #1 rst = 1'b1;
        #1;
        checkOutput("async_flush",  32'(flush),        32'h0);
        checkOutput("async_stall",  32'(stall),        32'h0);
        checkOutput("async_new_pc", new_pc,            32'h0);
        checkOutput("async_sc",     32'(stall_cycles), 32'h0);
        checkOutput("async_fe",     32'(flush_events), 32'h0);
        checkOutput("async_wdog",   32'(wdog_timeout), 32'h0);
        modelReset();
        @(negedge clk);
        rst      = 1'b0;
        stallreq = '0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus('0, 1'b0, 32'h0, 1'b0);
            checkModel();
            checkOutput("post_reset_idle", {stall, flush, wdog_timeout, 24'(0)}, 32'h0);
            clockEdge();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Parametrised pipeline control unit. Successor to the fixed 6-bit, two-requester stall controller.
- Accepts a stall request from any of NSTAGE pipeline stages and produces a thermometer stall vector.
- Adds a registered, multi-cycle flush with redirect PC, a stall watchdog, and saturating-free performance counters.
- Sits beside the stage chain at the CPU top level and drives the stall/flush inputs of pc_reg and every pipeline register.

Parameters:
- NSTAGE, 6, number of pipeline stages; bit 0 = pc, 1 = if, 2 = id, 3 = ex, 4 = mem, 5 = wb.
- PC_W, 32, width of the redirect PC.
- FLUSH_LEN, 1, cycles the flush output stays high per accepted flush (must be >= 1).
- WDOG_LIMIT, 255, consecutive stalled cycles before the watchdog fires (must be >= 1).
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- stallreq  in  NSTAGE  per-stage stall request; bit k is raised by stage k.
- flushreq  in  1  flush request (branch mispredict or exception), sampled on the clock edge.
- flush_pc_i  in  PC_W  redirect target, valid when flushreq = 1.
- clr_cnt  in  1  synchronous clear of the performance counters and the watchdog.
- stall  out  NSTAGE  stall vector to pc_reg and the pipeline registers.
- flush  out  1  flush pulse to all pipeline registers.
- new_pc  out  PC_W  redirect PC for pc_reg, valid while flush = 1.
- stall_cycles  out  CNT_W  count of cycles with stall[0] = 1.
- flush_events  out  CNT_W  count of accepted flushreq.
- wdog_timeout  out  1  sticky watchdog flag.

Behaviour:
- Reset (async, rst = 1): flush = 0, new_pc = 0, flush counter = 0, stall_cycles = 0, flush_events = 0, watchdog counter = 0, wdog_timeout = 0. While rst = 1, stall = all 0.
- Stall vector (combinational from stallreq and flush state):
  - Let h = highest index k with stallreq[k] = 1. Then stall[h:0] = 1 and stall[NSTAGE-1:h+1] = 0.
  - No request gives stall = 0.
  - Example (NSTAGE = 6): stallreq = 000100 gives stall = 000111; stallreq = 001010 gives stall = 001111.
- Flush has priority over stall: while flush = 1, stall = 0 regardless of stallreq.
- Flush sequencing:
  - flushreq = 1 at an edge captures new_pc <= flush_pc_i, loads the flush counter with FLUSH_LEN, and increments flush_events. flush goes high in the next cycle.
  - flush = (flush counter != 0). The counter decrements by 1 per cycle while nonzero.
  - flushreq while a flush is active restarts the flush: counter reloads to FLUSH_LEN, new_pc takes the new target, flush_events increments again. flush stays high with no gap.
  - When the counter reaches 0, flush drops. new_pc holds its last value.
  - Latency: flushreq at edge N gives flush = 1 for cycles N+1 .. N+FLUSH_LEN.
- Watchdog:
  - The counter increments on every cycle with stall != 0 and clears on any cycle with stall = 0.
  - When the counter reaches WDOG_LIMIT, wdog_timeout is set at that edge and the counter holds.
  - wdog_timeout clears only on rst or clr_cnt.
  - The watchdog does not alter stall; it is a debug/status output only.
- Performance counters:
  - stall_cycles increments on each cycle with stall[0] = 1.
  - Both counters wrap modulo 2^CNT_W; they do not saturate.
- clr_cnt:
  - Sets stall_cycles, flush_events, watchdog counter and wdog_timeout to 0 at the edge.
  - Takes priority over any increment in the same cycle.
  - Does not affect flush, the flush counter or new_pc.
- Simultaneous events: flushreq in a cycle where stall != 0 is still accepted. stall_cycles counts that cycle, because stall is evaluated before flush goes high.
- Reset mid-flush: rst asserted mid-flush drops flush and stall immediately, without waiting for a clock edge.

Test Plan:
- Thermometer: NSTAGE = 6, step stallreq through 000001, 000100, 001000, 101010, 000000 -> stall = 000001, 000111, 001111, 111111, 000000 in the same cycle.
- Flush: FLUSH_LEN = 2, flushreq = 1 with flush_pc_i = 0x0000_0100 at edge 5 -> flush = 1 in cycles 6-7, new_pc = 0x100, flush_events = 1; stallreq = 001000 held throughout -> stall = 0 in cycles 6-7 and 001111 again in cycle 8.
- Back-to-back flush: FLUSH_LEN = 3, flushreq at edges 10 (pc 0x200) and 12 (pc 0x300) -> flush high in cycles 11-15 with no gap, new_pc = 0x300 from cycle 13, flush_events = 2.
- Watchdog: WDOG_LIMIT = 4, stallreq = 000100 held for 3 cycles then released -> no timeout. Then held for 4 cycles -> wdog_timeout = 1 at the 4th edge and stays 1 after release. clr_cnt pulse -> 0.
- Counter wrap: CNT_W = 4, stallreq[0] held for 17 cycles -> stall_cycles = 1. clr_cnt together with stallreq[0] = 1 -> stall_cycles = 0.
- Async reset: assert rst mid-flush between clock edges -> flush, stall, new_pc and all counters go to 0 immediately. After release, with no requests, all outputs stay 0.
